// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: bubbles on freeze, selects the write-back value,
// and keeps saturating retire/stall performance counters.
module mem_wb_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEST_W   = 5,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [DATA_W-1:0] PC_in,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] MEM_read_value_in,
  input  logic [DEST_W-1:0] Dest_in,
  input  logic              clr_counters,
  output logic [DATA_W-1:0] PC,
  output logic              WB_en,
  output logic [DEST_W-1:0] WB_Dest,
  output logic [DATA_W-1:0] WB_Value,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic              wb_en_q, wb_en_d;
  logic              mem_r_en_q, mem_r_en_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] rdval_q, rdval_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              retire_ev_c;
  logic              zero_block_c;

  // Pipeline capture; a frozen edge only kills the enables so nothing writes twice
  always_comb begin
    pc_d       = pc_q;
    wb_en_d    = 1'b0;
    mem_r_en_d = 1'b0;
    alu_d      = alu_q;
    rdval_d    = rdval_q;
    dest_d     = dest_q;
    if (!freeze) begin
      pc_d       = PC_in;
      wb_en_d    = WB_en_in;
      mem_r_en_d = MEM_R_EN_in;
      alu_d      = ALU_result_in;
      rdval_d    = MEM_read_value_in;
      dest_d     = Dest_in;
    end
  end

  // Saturating counters; clear wins over any increment on the same edge
  always_comb begin
    retire_ev_c = !freeze && (WB_en_in || MEM_W_EN_in);
    retire_d    = retire_q;
    stall_d     = stall_q;
    if (clr_counters) begin
      retire_d = '0;
      stall_d  = '0;
    end else begin
      if (retire_ev_c && (retire_q != '1)) retire_d = retire_q + CNT_W'(1);
      if (freeze && (stall_q != '1))       stall_d  = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_q      <= '0;
      rdval_q    <= '0;
      dest_q     <= '0;
      retire_q   <= '0;
      stall_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      alu_q      <= alu_d;
      rdval_q    <= rdval_d;
      dest_q     <= dest_d;
      retire_q   <= retire_d;
      stall_q    <= stall_d;
    end
  end

  // Write-back mux and zero-register suppression straight from the flops
  always_comb begin
    zero_block_c = (ZERO_REG != 0) && (dest_q == '0);
    PC           = pc_q;
    WB_Dest      = dest_q;
    WB_Value     = mem_r_en_q ? rdval_q : alu_q;
    WB_en        = wb_en_q && !zero_block_c;
    fwd_valid    = WB_en;
    retire_cnt   = retire_q;
    stall_cnt    = stall_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a default build plus a CNT_W=4 build
// sharing the same stimulus for counter saturation.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [31:0] PC_in;
  logic        WB_en_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  logic [31:0] ALU_result_in;
  logic [31:0] MEM_read_value_in;
  logic [4:0]  Dest_in;
  logic        clr_counters;

  logic [31:0] PC;
  logic        WB_en;
  logic [4:0]  WB_Dest;
  logic [31:0] WB_Value;
  logic        fwd_valid;
  logic [31:0] retire_cnt;
  logic [31:0] stall_cnt;

  logic [31:0] s_PC;
  logic        s_WB_en;
  logic [4:0]  s_WB_Dest;
  logic [31:0] s_WB_Value;
  logic        s_fwd_valid;
  logic [3:0]  s_retire_cnt;
  logic [3:0]  s_stall_cnt;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .PC_in(PC_in), .WB_en_in(WB_en_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .ALU_result_in(ALU_result_in),
    .MEM_read_value_in(MEM_read_value_in), .Dest_in(Dest_in), .clr_counters(clr_counters),
    .PC(PC), .WB_en(WB_en), .WB_Dest(WB_Dest), .WB_Value(WB_Value), .fwd_valid(fwd_valid),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  mem_wb_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .freeze(freeze), .PC_in(PC_in), .WB_en_in(WB_en_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .ALU_result_in(ALU_result_in),
    .MEM_read_value_in(MEM_read_value_in), .Dest_in(Dest_in), .clr_counters(clr_counters),
    .PC(s_PC), .WB_en(s_WB_en), .WB_Dest(s_WB_Dest), .WB_Value(s_WB_Value),
    .fwd_valid(s_fwd_valid), .retire_cnt(s_retire_cnt), .stall_cnt(s_stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic we, input logic re, input logic st,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] dst);
    PC_in = pc; WB_en_in = we; MEM_R_EN_in = re; MEM_W_EN_in = st;
    ALU_result_in = alu; MEM_read_value_in = rd; Dest_in = dst;
  endtask

  task automatic test_reset();
    rst = 1'b1; freeze = 1'b0; clr_counters = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #12;
    tests_run++; if (WB_en !== 1'b0 || fwd_valid !== 1'b0) begin failed++; $display("FAIL reset_en: got %b/%b want 0/0", WB_en, fwd_valid); end
    tests_run++; if (PC !== 32'h0 || WB_Value !== 32'h0 || WB_Dest !== 5'd0) begin failed++; $display("FAIL reset_data: got %h/%h/%h want 0", PC, WB_Value, WB_Dest); end
    tests_run++; if (retire_cnt !== 32'h0 || stall_cnt !== 32'h0) begin failed++; $display("FAIL reset_cnt: got %h/%h want 0/0", retire_cnt, stall_cnt); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_alu_pass();
    drive(32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h5555_5555, 5'd7);
    step();
    tests_run++; if (WB_en !== 1'b1 || fwd_valid !== 1'b1) begin failed++; $display("FAIL alu_en: got %b/%b want 1/1", WB_en, fwd_valid); end
    tests_run++; if (WB_Dest !== 5'd7) begin failed++; $display("FAIL alu_dest: got %0d want 7", WB_Dest); end
    tests_run++; if (WB_Value !== 32'h0000_1234) begin failed++; $display("FAIL alu_value: got %h want 00001234", WB_Value); end
    tests_run++; if (PC !== 32'h0000_0100) begin failed++; $display("FAIL alu_pc: got %h want 00000100", PC); end
    tests_run++; if (retire_cnt !== 32'd1) begin failed++; $display("FAIL alu_retire: got %0d want 1", retire_cnt); end
  endtask

  task automatic test_load_select();
    drive(32'h0000_0104, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 5'd3);
    step();
    tests_run++; if (WB_Value !== 32'hDEAD_BEEF) begin failed++; $display("FAIL load_value: got %h want deadbeef", WB_Value); end
    tests_run++; if (WB_en !== 1'b1 || WB_Dest !== 5'd3) begin failed++; $display("FAIL load_en_dest: got %b/%0d want 1/3", WB_en, WB_Dest); end
    tests_run++; if (retire_cnt !== 32'd2) begin failed++; $display("FAIL load_retire: got %0d want 2", retire_cnt); end
  endtask

  task automatic test_freeze_bubble();
    drive(32'h0000_0108, 1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_F00D, 5'd9);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++; if (WB_en !== 1'b0) begin failed++; $display("FAIL freeze_bubble_%0d: got WB_en=%b want 0", i, WB_en); end
    end
    tests_run++; if (stall_cnt !== 32'd4) begin failed++; $display("FAIL freeze_stall: got %0d want 4", stall_cnt); end
    tests_run++; if (retire_cnt !== 32'd2) begin failed++; $display("FAIL freeze_retire_hold: got %0d want 2", retire_cnt); end
    tests_run++; if (PC !== 32'h0000_0104) begin failed++; $display("FAIL freeze_pc_hold: got %h want 00000104", PC); end
    freeze = 1'b0;
    step();
    tests_run++; if (WB_en !== 1'b1 || WB_Dest !== 5'd9) begin failed++; $display("FAIL release_en_dest: got %b/%0d want 1/9", WB_en, WB_Dest); end
    tests_run++; if (WB_Value !== 32'hCAFE_F00D) begin failed++; $display("FAIL release_value: got %h want cafef00d", WB_Value); end
    tests_run++; if (retire_cnt !== 32'd3) begin failed++; $display("FAIL release_retire: got %0d want 3", retire_cnt); end
    drive(32'h0000_010C, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd9);
    step();
    tests_run++; if (WB_en !== 1'b0 || retire_cnt !== 32'd3) begin failed++; $display("FAIL single_pulse: got %b/%0d want 0/3", WB_en, retire_cnt); end
  endtask

  task automatic test_zero_reg();
    drive(32'h0000_0110, 1'b1, 1'b0, 1'b0, 32'h0000_0005, 32'h0, 5'd0);
    step();
    tests_run++; if (WB_en !== 1'b0 || fwd_valid !== 1'b0) begin failed++; $display("FAIL zero_en: got %b/%b want 0/0", WB_en, fwd_valid); end
    tests_run++; if (WB_Value !== 32'h5 || retire_cnt !== 32'd4) begin failed++; $display("FAIL zero_value_retire: got %h/%0d want 5/4", WB_Value, retire_cnt); end
  endtask

  task automatic test_store_only();
    drive(32'h0000_0114, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 5'd4);
    step();
    tests_run++; if (WB_en !== 1'b0 || retire_cnt !== 32'd5) begin failed++; $display("FAIL store: got %b/%0d want 0/5", WB_en, retire_cnt); end
    MEM_W_EN_in = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h0000_0118, 1'b1, 1'b0, 1'b0, 32'h0000_0009, 32'h0, 5'd6);
    step();
    tests_run++; if (WB_en !== 1'b1) begin failed++; $display("FAIL pre_reset_en: got %b want 1", WB_en); end
    freeze = 1'b1;
    #2 rst = 1'b1;
    #1;
    tests_run++; if (WB_en !== 1'b0 || PC !== 32'h0 || WB_Value !== 32'h0 || WB_Dest !== 5'd0) begin failed++; $display("FAIL async_reset: got %b/%h/%h/%0d want 0", WB_en, PC, WB_Value, WB_Dest); end
    tests_run++; if (retire_cnt !== 32'h0 || stall_cnt !== 32'h0) begin failed++; $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", retire_cnt, stall_cnt); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    step();
    tests_run++; if (WB_en !== 1'b0 || PC !== 32'h0 || WB_Dest !== 5'd0) begin failed++; $display("FAIL post_reset_frozen: got %b/%h/%0d want 0", WB_en, PC, WB_Dest); end
    tests_run++; if (stall_cnt !== 32'd1 || retire_cnt !== 32'd0) begin failed++; $display("FAIL post_reset_cnt: got %0d/%0d want 1/0", stall_cnt, retire_cnt); end
  endtask

  task automatic test_counters();
    clr_counters = 1'b1;
    step();
    tests_run++; if (stall_cnt !== 32'd0) begin failed++; $display("FAIL clr_priority: got %0d want 0", stall_cnt); end
    tests_run++; if (s_stall_cnt !== 4'd0) begin failed++; $display("FAIL clr_priority_small: got %0d want 0", s_stall_cnt); end
    clr_counters = 1'b0;
    for (int i = 0; i < 20; i++) step();
    tests_run++; if (s_stall_cnt !== 4'hF) begin failed++; $display("FAIL stall_saturate: got %h want f", s_stall_cnt); end
    tests_run++; if (stall_cnt !== 32'd20) begin failed++; $display("FAIL stall_count20: got %0d want 20", stall_cnt); end
    step();
    tests_run++; if (s_stall_cnt !== 4'hF) begin failed++; $display("FAIL stall_no_wrap: got %h want f", s_stall_cnt); end
    clr_counters = 1'b1;
    step();
    tests_run++; if (s_stall_cnt !== 4'h0 || stall_cnt !== 32'd0) begin failed++; $display("FAIL clr_after_sat: got %h/%0d want 0/0", s_stall_cnt, stall_cnt); end
    clr_counters = 1'b0; freeze = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_load_select();
    test_freeze_bubble();
    test_zero_reg();
    test_store_only();
    test_reset_mid_stall();
    test_counters();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
